// File: rtl/histogram_pkg.sv
// Shared widths, FSM state encoding and the pixel-to-bin mapping for the histogram engine.
package histogram_pkg;
   localparam int DEF_PIXEL_W = 10;
   localparam int DEF_BIN_W   = 10;
   localparam int DEF_COUNT_W = 24;

   typedef enum logic [1:0] {
      CLEAR   = 2'd0,
      ACCUM   = 2'd1,
      DRAIN   = 2'd2,
      READOUT = 2'd3
   } state_t;

   // The bin is the top bin_w bits of the pixel.
   function automatic logic [31:0] pixel_to_bin(input logic [31:0] pix,
                                                input int unsigned pixel_w,
                                                input int unsigned bin_w);
      return pix >> (pixel_w - bin_w);
   endfunction
endpackage

// File: rtl/hist_ram_sdp.sv
// Simple dual-port RAM: one write port, one read port with a 1-cycle registered read.
// Read-during-write to the same address returns the old contents; q holds while re is low.
module hist_ram_sdp #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] q
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) q <= mem[raddr];
   end
endmodule

// File: rtl/histogram_accum.sv
// Frame histogram: 3-stage forwarded read-modify-write at 1 pixel/cycle, then read-and-clear
// streaming of every bin over rd_valid/rd_ready; first beat 2 cycles into READOUT, holds under stall.
module histogram_accum
   import histogram_pkg::*;
#(
   parameter int PIXEL_W  = DEF_PIXEL_W,
   parameter int BIN_W    = DEF_BIN_W,
   parameter int COUNT_W  = DEF_COUNT_W,
   parameter bit SATURATE = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIXEL_W-1:0] pixel,
   input  logic               pixel_valid,
   output logic               pixel_ready,
   input  logic               image_done,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [BIN_W-1:0]   rd_bin,
   output logic [COUNT_W-1:0] rd_data,
   output logic               rd_last,
   output logic               histo_done,
   output logic               overflow
);
   localparam logic [BIN_W-1:0]   BIN_MAX   = '1;
   localparam logic [BIN_W:0]     SWEEP_ONE = (BIN_W+1)'(1);
   localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

   state_t             state, state_n;
   logic [BIN_W:0]     sweep, sweep_n;

   logic [BIN_W-1:0]   pix_bin;
   logic               pix_acc, rd_hs, load_out, rd_issue, s2_ovf;

   logic               s1_vld, s2_vld;
   logic [BIN_W-1:0]   s1_bin, s2_bin;
   logic [COUNT_W-1:0] s1_fwd, s2_old, s2_new;

   logic               lw_vld;
   logic [BIN_W-1:0]   lw_bin;
   logic [COUNT_W-1:0] lw_val;

   logic               q_vld;
   logic [BIN_W-1:0]   q_bin;

   logic               ram_we, ram_re;
   logic [BIN_W-1:0]   ram_waddr, ram_raddr;
   logic [COUNT_W-1:0] ram_wdata, ram_q;

   assign pix_bin     = BIN_W'(pixel_to_bin(32'(pixel), PIXEL_W, BIN_W));
   assign pixel_ready = (state == ACCUM);
   assign pix_acc     = pixel_valid && pixel_ready;
   assign rd_hs       = rd_valid && rd_ready;
   // The RAM q register acts as a one-deep stage in front of the output beat.
   assign load_out    = q_vld && (!rd_valid || rd_ready);
   assign rd_issue    = (state == READOUT) && !sweep[BIN_W] && (!q_vld || load_out);
   assign s2_ovf      = s2_vld && (s2_old == CNT_MAX);

   always_comb begin
      s2_new = s2_old + CNT_ONE;
      if (s2_old == CNT_MAX) s2_new = SATURATE ? CNT_MAX : '0;
   end

   // RAM q is stale for a bin written this cycle (S2) or last cycle (lw).
   always_comb begin
      s1_fwd = ram_q;
      if (s2_vld && (s2_bin == s1_bin))      s1_fwd = s2_new;
      else if (lw_vld && (lw_bin == s1_bin)) s1_fwd = lw_val;
   end

   always_comb begin
      state_n   = state;
      sweep_n   = sweep;
      ram_re    = 1'b0;
      ram_raddr = pix_bin;
      ram_we    = 1'b0;
      ram_waddr = s2_bin;
      ram_wdata = s2_new;
      case (state)
         CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = sweep[BIN_W-1:0];
            ram_wdata = '0;
            if (sweep[BIN_W-1:0] == BIN_MAX) begin
               state_n = ACCUM;
               sweep_n = '0;
            end else begin
               sweep_n = sweep + SWEEP_ONE;
            end
         end
         ACCUM: begin
            ram_re = pix_acc;
            if (image_done) state_n = DRAIN;
         end
         DRAIN: begin
            if (sweep[0]) begin
               state_n = READOUT;
               sweep_n = '0;
            end else begin
               sweep_n = sweep + SWEEP_ONE;
            end
         end
         READOUT: begin
            ram_re    = rd_issue;
            ram_raddr = sweep[BIN_W-1:0];
            if (rd_issue) sweep_n = sweep + SWEEP_ONE;
            if (rd_hs && rd_last) begin
               state_n = ACCUM;
               sweep_n = '0;
            end
         end
         default: state_n = CLEAR;
      endcase
      if (s2_vld) begin
         ram_we    = 1'b1;
         ram_waddr = s2_bin;
         ram_wdata = s2_new;
      end
      if (rd_hs) begin
         ram_we    = 1'b1;
         ram_waddr = rd_bin;
         ram_wdata = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         sweep <= '0;
      end else begin
         state <= state_n;
         sweep <= sweep_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld     <= 1'b0;
         s1_bin     <= '0;
         s2_vld     <= 1'b0;
         s2_bin     <= '0;
         s2_old     <= '0;
         lw_vld     <= 1'b0;
         lw_bin     <= '0;
         lw_val     <= '0;
         q_vld      <= 1'b0;
         q_bin      <= '0;
         rd_valid   <= 1'b0;
         rd_bin     <= '0;
         rd_data    <= '0;
         rd_last    <= 1'b0;
         histo_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         s1_vld <= pix_acc;
         s1_bin <= pix_bin;
         s2_vld <= s1_vld;
         s2_bin <= s1_bin;
         s2_old <= s1_fwd;
         lw_vld <= ram_we;
         lw_bin <= ram_waddr;
         lw_val <= ram_wdata;

         if (rd_issue) begin
            q_vld <= 1'b1;
            q_bin <= sweep[BIN_W-1:0];
         end else if (load_out) begin
            q_vld <= 1'b0;
         end

         if (load_out) begin
            rd_valid <= 1'b1;
            rd_bin   <= q_bin;
            rd_data  <= ram_q;
            rd_last  <= (q_bin == BIN_MAX);
         end else if (rd_hs) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
         end

         histo_done <= rd_hs && rd_last;
         if (rd_hs && rd_last) overflow <= 1'b0;
         else if (s2_ovf)      overflow <= 1'b1;
      end
   end

   hist_ram_sdp #(
      .ADDR_W (BIN_W),
      .DATA_W (COUNT_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (ram_raddr),
      .q     (ram_q)
   );
endmodule

// File: tb/tb_histogram_accum.sv
// Random-stimulus bench: one default-width instance plus a saturating and a wrapping
// BIN_W=6/COUNT_W=4 pair, all checked against per-instance count arrays.
module tb_histogram_accum;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [9:0]  m_pixel;
   logic        m_pixel_valid, m_pixel_ready, m_image_done;
   logic        m_rd_valid, m_rd_ready, m_rd_last, m_histo_done, m_overflow;
   logic [9:0]  m_rd_bin;
   logic [23:0] m_rd_data;

   logic [9:0]  s_pixel;
   logic        s_pixel_valid, s_image_done, s_rd_ready;
   logic        sa_pixel_ready, sa_rd_valid, sa_rd_last, sa_histo_done, sa_overflow;
   logic [5:0]  sa_rd_bin;
   logic [3:0]  sa_rd_data;
   logic        wr_pixel_ready, wr_rd_valid, wr_rd_last, wr_histo_done, wr_overflow;
   logic [5:0]  wr_rd_bin;
   logic [3:0]  wr_rd_data;

   histogram_accum u_main (
      .clk(clk), .rst(rst), .pixel(m_pixel), .pixel_valid(m_pixel_valid),
      .pixel_ready(m_pixel_ready), .image_done(m_image_done), .rd_valid(m_rd_valid),
      .rd_ready(m_rd_ready), .rd_bin(m_rd_bin), .rd_data(m_rd_data), .rd_last(m_rd_last),
      .histo_done(m_histo_done), .overflow(m_overflow)
   );

   histogram_accum #(.PIXEL_W(10), .BIN_W(6), .COUNT_W(4), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .pixel(s_pixel), .pixel_valid(s_pixel_valid),
      .pixel_ready(sa_pixel_ready), .image_done(s_image_done), .rd_valid(sa_rd_valid),
      .rd_ready(s_rd_ready), .rd_bin(sa_rd_bin), .rd_data(sa_rd_data), .rd_last(sa_rd_last),
      .histo_done(sa_histo_done), .overflow(sa_overflow)
   );

   histogram_accum #(.PIXEL_W(10), .BIN_W(6), .COUNT_W(4), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .pixel(s_pixel), .pixel_valid(s_pixel_valid),
      .pixel_ready(wr_pixel_ready), .image_done(s_image_done), .rd_valid(wr_rd_valid),
      .rd_ready(s_rd_ready), .rd_bin(wr_rd_bin), .rd_data(wr_rd_data), .rd_last(wr_rd_last),
      .histo_done(wr_histo_done), .overflow(wr_overflow)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference histograms: one count per bin plus the sticky overflow flag.
   int unsigned cnt_m [1024];
   int unsigned cnt_s [64];
   int unsigned cnt_w [64];
   bit          ovf_m, ovf_s, ovf_w;
   int          frame_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void clear_models();
      foreach (cnt_m[i]) cnt_m[i] = 0;
      foreach (cnt_s[i]) cnt_s[i] = 0;
      foreach (cnt_w[i]) cnt_w[i] = 0;
      ovf_m = 1'b0;
      ovf_s = 1'b0;
      ovf_w = 1'b0;
   endfunction

   // Full-width instance: bin is the pixel itself, 24-bit saturating counters.
   function automatic void acc_main(input int p);
      if (cnt_m[p] + 1 > 32'hFF_FFFF) ovf_m = 1'b1;
      else                             cnt_m[p] = cnt_m[p] + 1;
   endfunction

   // 6-bit bins from a 10-bit pixel, 4-bit counters: clamp at 15 or wrap mod 16.
   function automatic void acc_small(input int p);
      int b;
      b = p / 16;
      if (cnt_s[b] + 1 > 15) ovf_s = 1'b1;
      else                   cnt_s[b] = cnt_s[b] + 1;
      if (cnt_w[b] + 1 > 15) ovf_w = 1'b1;
      cnt_w[b] = (cnt_w[b] + 1) % 16;
   endfunction

   function automatic void fill_main_rand(input int n);
      int r;
      frame_q.delete();
      for (int i = 0; i < n; i++) begin
         r = int'($urandom_range(0, 4));
         case (r)
            0: frame_q.push_back(0);
            1: frame_q.push_back(1);
            2: frame_q.push_back(1023);
            default: frame_q.push_back(int'($urandom_range(0, 1023)));
         endcase
      end
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!m_pixel_ready && n < 3000);
      chk("clear_cycles", 32'(n), 1024);
   endtask

   // Drives frame_q with image_done on the last pixel; leaves that beat on the inputs.
   task automatic main_frame(input bit gaps);
      int n;
      n = frame_q.size();
      @(negedge clk);
      chk("m_frame_rdy", 32'(m_pixel_ready), 1);
      if (n == 0) begin
         m_pixel_valid = 1'b0;
         m_image_done  = 1'b1;
      end
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         while (gaps && $urandom_range(0, 3) == 0) begin
            m_pixel_valid = 1'b0;
            m_image_done  = 1'b0;
            @(negedge clk);
         end
         m_pixel       = 10'(frame_q[i]);
         m_pixel_valid = 1'b1;
         m_image_done  = (i == n - 1);
         acc_main(frame_q[i]);
      end
   endtask

   task automatic main_readout(input bit rnd, input int abort_at);
      int  beat, cyc;
      bit  seen;
      beat = 0;
      cyc  = 0;
      seen = 1'b0;
      while (beat < 1024 && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk("m_rdy_drop", 32'(m_pixel_ready), 0);
         if (!seen && m_rd_valid) begin
            seen = 1'b1;
            chk("m_first_beat_cyc", 32'(cyc), 5);
         end
         if (seen) chk($sformatf("m_vld_gap[%0d]", beat), 32'(m_rd_valid), 1);
         if (m_rd_valid) begin
            chk($sformatf("m_bin[%0d]", beat), 32'(m_rd_bin), beat);
            chk($sformatf("m_data[%0d]", beat), 32'(m_rd_data), cnt_m[beat]);
            chk($sformatf("m_last[%0d]", beat), 32'(m_rd_last), 32'(beat == 1023));
            if (beat == 0) chk("m_ovf_frame", 32'(m_overflow), 32'(ovf_m));
         end
         if (abort_at >= 0 && beat == abort_at && m_rd_valid) begin
            rst = 1'b1;
            #1;
            chk("rst_rd_valid", 32'(m_rd_valid), 0);
            chk("rst_rd_bin", 32'(m_rd_bin), 0);
            chk("rst_rd_data", 32'(m_rd_data), 0);
            chk("rst_rd_last", 32'(m_rd_last), 0);
            chk("rst_pixel_ready", 32'(m_pixel_ready), 0);
            chk("rst_overflow", 32'(m_overflow), 0);
            m_pixel_valid = 1'b0;
            m_image_done  = 1'b0;
            m_rd_ready    = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            clear_models();
            wait_ready();
            return;
         end
         m_rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rnd && beat < 1000) begin
            m_pixel       = 10'($urandom_range(0, 1023));
            m_pixel_valid = 1'($urandom_range(0, 1));
            m_image_done  = 1'($urandom_range(0, 1));
         end else begin
            m_pixel_valid = 1'b0;
            m_image_done  = 1'b0;
         end
         if (m_rd_valid && m_rd_ready) beat++;
      end
      chk("m_beats", 32'(beat), 1024);
      @(negedge clk);
      m_rd_ready = 1'b0;
      chk("m_histo_done", 32'(m_histo_done), 1);
      chk("m_vld_after_last", 32'(m_rd_valid), 0);
      chk("m_ovf_cleared", 32'(m_overflow), 0);
      chk("m_back_to_accum", 32'(m_pixel_ready), 1);
      @(negedge clk);
      chk("m_histo_done_pulse", 32'(m_histo_done), 0);
      foreach (cnt_m[i]) cnt_m[i] = 0;
      ovf_m = 1'b0;
   endtask

   task automatic small_frame();
      int n;
      n = frame_q.size();
      @(negedge clk);
      chk("sa_frame_rdy", 32'(sa_pixel_ready), 1);
      chk("wr_frame_rdy", 32'(wr_pixel_ready), 1);
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         s_pixel       = 10'(frame_q[i]);
         s_pixel_valid = 1'b1;
         s_image_done  = (i == n - 1);
         acc_small(frame_q[i]);
      end
   endtask

   task automatic small_readout();
      int beat, cyc;
      beat = 0;
      cyc  = 0;
      while (beat < 64 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         s_pixel_valid = 1'b0;
         s_image_done  = 1'b0;
         if (sa_rd_valid) begin
            chk($sformatf("sa_bin[%0d]", beat), 32'(sa_rd_bin), beat);
            chk($sformatf("sa_data[%0d]", beat), 32'(sa_rd_data), cnt_s[beat]);
            chk($sformatf("sa_last[%0d]", beat), 32'(sa_rd_last), 32'(beat == 63));
            chk($sformatf("wr_vld[%0d]", beat), 32'(wr_rd_valid), 1);
            chk($sformatf("wr_bin[%0d]", beat), 32'(wr_rd_bin), beat);
            chk($sformatf("wr_data[%0d]", beat), 32'(wr_rd_data), cnt_w[beat]);
            if (beat == 0) begin
               chk("sa_ovf_frame", 32'(sa_overflow), 32'(ovf_s));
               chk("wr_ovf_frame", 32'(wr_overflow), 32'(ovf_w));
            end
         end
         s_rd_ready = 1'($urandom_range(0, 1));
         if (sa_rd_valid && s_rd_ready) beat++;
      end
      chk("s_beats", 32'(beat), 64);
      @(negedge clk);
      s_rd_ready = 1'b0;
      chk("sa_histo_done", 32'(sa_histo_done), 1);
      chk("wr_histo_done", 32'(wr_histo_done), 1);
      chk("sa_ovf_cleared", 32'(sa_overflow), 0);
      chk("wr_ovf_cleared", 32'(wr_overflow), 0);
      foreach (cnt_s[i]) cnt_s[i] = 0;
      foreach (cnt_w[i]) cnt_w[i] = 0;
      ovf_s = 1'b0;
      ovf_w = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      m_pixel       = '0;
      m_pixel_valid = 1'b0;
      m_image_done  = 1'b0;
      m_rd_ready    = 1'b0;
      s_pixel       = '0;
      s_pixel_valid = 1'b0;
      s_image_done  = 1'b0;
      s_rd_ready    = 1'b0;
      clear_models();
      repeat (3) @(negedge clk);
      chk("reset_pixel_ready", 32'(m_pixel_ready), 0);
      chk("reset_rd_valid", 32'(m_rd_valid), 0);
      chk("reset_rd_bin", 32'(m_rd_bin), 0);
      chk("reset_rd_data", 32'(m_rd_data), 0);
      chk("reset_rd_last", 32'(m_rd_last), 0);
      chk("reset_histo_done", 32'(m_histo_done), 0);
      chk("reset_overflow", 32'(m_overflow), 0);
      rst = 1'b0;
      wait_ready();

      frame_q.delete();
      main_frame(1'b0);
      main_readout(1'b0, -1);

      frame_q = '{3, 3, 3, 5, 3, 5, 5};
      main_frame(1'b0);
      main_readout(1'b0, -1);

      fill_main_rand(400);
      main_frame(1'b1);
      main_readout(1'b1, -1);

      frame_q = '{0, 0};
      main_frame(1'b0);
      main_readout(1'b1, -1);

      fill_main_rand(200);
      main_frame(1'b1);
      main_readout(1'b1, 100);

      fill_main_rand(60);
      main_frame(1'b0);
      main_readout(1'b1, -1);

      frame_q.delete();
      for (int i = 0; i < 20; i++) frame_q.push_back(9 * 16);
      small_frame();
      small_readout();

      frame_q = '{1023, 1008};
      small_frame();
      small_readout();

      frame_q.delete();
      for (int i = 0; i < 150; i++)
         frame_q.push_back(int'($urandom_range(0, 3)) * 256 + int'($urandom_range(0, 15)));
      small_frame();
      small_readout();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
      $fatal(1, "watchdog expired");
   end
endmodule
